// File: rtl/memory_access_stage.sv
// memory_access_stage
//   MEM stage of the 5-stage MIPS pipeline. Takes the XM_* register set from
//   EX, runs lw/sw over a req/ack data-memory bus, freezes the upstream stages
//   until the access completes, and loads the MW_* register set for WB.
//   The branch decision and target pass straight through to IF.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   XM_MemtoReg/RegWrite     writeback controls from EX
//   XM_MemRead/MemWrite      lw / sw in MEM
//   XM_branch, XM_BT         branch taken / target (passed to pc_src/pc_target)
//   ALUout                   effective address or ALU result
//   XM_RD, XM_SD             destination register, store data
//   mem_rdata, mem_ack       memory read data, single-cycle completion pulse
//   mem_req/we/addr/wdata    registered bus request
//   mem_stall                freeze IF/ID/EX and XM (combinational)
//   MW_*                     pipeline register feeding writeback
//   misalign_err, bus_err    one-cycle error pulses
module memory_access_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        XM_MemtoReg,
    input  logic        XM_RegWrite,
    input  logic        XM_MemRead,
    input  logic        XM_MemWrite,
    input  logic        XM_branch,
    input  logic [31:0] ALUout,
    input  logic [31:0] XM_BT,
    input  logic [4:0]  XM_RD,
    input  logic [31:0] XM_SD,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        MW_MemtoReg,
    output logic        MW_RegWrite,
    output logic [31:0] MW_ALUout,
    output logic [31:0] MW_MemData,
    output logic [4:0]  MW_RD,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             mw_memtoreg_q, mw_memtoreg_d;
    logic             mw_regwrite_q, mw_regwrite_d;
    logic [31:0]      mw_aluout_q, mw_aluout_d;
    logic [31:0]      mw_memdata_q, mw_memdata_d;
    logic [4:0]       mw_rd_q, mw_rd_d;
    logic             misalign_err_q, misalign_err_d;
    logic             bus_err_q, bus_err_d;

    logic mem_op;
    logic aligned;

    assign mem_op  = XM_MemRead | XM_MemWrite;
    assign aligned = (ALUout[1:0] == 2'b00);

    // Gated by rst so the freeze releases the instant reset is applied, even
    // if XM still holds a memory op while the state register is held in IDLE.
    assign mem_stall = ~rst & (((state_q == IDLE) & mem_op & aligned) |
                               (state_q == REQ));

    assign pc_src    = XM_branch;
    assign pc_target = XM_BT;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        abort_d        = abort_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mw_memtoreg_d  = mw_memtoreg_q;
        mw_regwrite_d  = mw_regwrite_q;
        mw_aluout_d    = mw_aluout_q;
        mw_memdata_d   = mw_memdata_q;
        mw_rd_d        = mw_rd_q;
        misalign_err_d = 1'b0;
        bus_err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_op && aligned) begin
                    state_d       = REQ;
                    mem_req_d     = 1'b1;
                    mem_we_d      = XM_MemWrite;
                    mem_addr_d    = ALUout;
                    mem_wdata_d   = XM_SD;
                    cnt_d         = '0;
                    mw_regwrite_d = 1'b0;
                    mw_memtoreg_d = 1'b0;
                    mw_rd_d       = '0;
                end else if (mem_op) begin
                    // Misaligned: drop the instruction, never touch the bus.
                    misalign_err_d = 1'b1;
                    mw_regwrite_d  = 1'b0;
                    mw_memtoreg_d  = 1'b0;
                    mw_rd_d        = '0;
                end else begin
                    mw_memtoreg_d = XM_MemtoReg;
                    mw_regwrite_d = XM_RegWrite;
                    mw_aluout_d   = ALUout;
                    mw_rd_d       = XM_RD;
                end
            end

            REQ: begin
                mw_regwrite_d = 1'b0;
                mw_memtoreg_d = 1'b0;
                mw_rd_d       = '0;
                // Ack is tested first so it wins over a coincident timeout.
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        mw_memdata_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    abort_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                // XM is still frozen on the memory instruction here; it
                // advances on this same edge because the stall has dropped.
                mw_memtoreg_d = XM_MemtoReg;
                mw_regwrite_d = XM_RegWrite & ~abort_q;
                mw_aluout_d   = ALUout;
                mw_rd_d       = XM_RD;
                abort_d       = 1'b0;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            abort_q        <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mw_memtoreg_q  <= 1'b0;
            mw_regwrite_q  <= 1'b0;
            mw_aluout_q    <= '0;
            mw_memdata_q   <= '0;
            mw_rd_q        <= '0;
            misalign_err_q <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            abort_q        <= abort_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mw_memtoreg_q  <= mw_memtoreg_d;
            mw_regwrite_q  <= mw_regwrite_d;
            mw_aluout_q    <= mw_aluout_d;
            mw_memdata_q   <= mw_memdata_d;
            mw_rd_q        <= mw_rd_d;
            misalign_err_q <= misalign_err_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign MW_MemtoReg  = mw_memtoreg_q;
    assign MW_RegWrite  = mw_regwrite_q;
    assign MW_ALUout    = mw_aluout_q;
    assign MW_MemData   = mw_memdata_q;
    assign MW_RD        = mw_rd_q;
    assign misalign_err = misalign_err_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage
//   Directed bench for memory_access_stage: lw/sw handshakes, misalignment,
//   timeout abort, ack racing the timeout, and reset in the middle of an access.
module tb_memory_access_stage;

    logic        clk;
    logic        rst;
    logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch;
    logic [31:0] ALUout, XM_BT, XM_SD, mem_rdata;
    logic [4:0]  XM_RD;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_stall, pc_src;
    logic [31:0] mem_addr, mem_wdata, pc_target;
    logic        MW_MemtoReg, MW_RegWrite;
    logic [31:0] MW_ALUout, MW_MemData;
    logic [4:0]  MW_RD;
    logic        misalign_err, bus_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned req_cycles;

    memory_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
        .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
        .XM_branch(XM_branch), .ALUout(ALUout), .XM_BT(XM_BT),
        .XM_RD(XM_RD), .XM_SD(XM_SD),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_stall(mem_stall),
        .pc_src(pc_src), .pc_target(pc_target),
        .MW_MemtoReg(MW_MemtoReg), .MW_RegWrite(MW_RegWrite),
        .MW_ALUout(MW_ALUout), .MW_MemData(MW_MemData), .MW_RD(MW_RD),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        XM_MemtoReg = 1'b0; XM_RegWrite = 1'b0;
        XM_MemRead  = 1'b0; XM_MemWrite = 1'b0;
        XM_branch   = 1'b0; XM_BT = '0;
        ALUout = '0; XM_RD = '0; XM_SD = '0;
    endtask

    task automatic set_lw(input logic [31:0] addr, input logic [4:0] rd);
        XM_MemtoReg = 1'b1; XM_RegWrite = 1'b1;
        XM_MemRead  = 1'b1; XM_MemWrite = 1'b0;
        ALUout = addr; XM_RD = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_nop();
        mem_ack = 1'b0; mem_rdata = '0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mw_regwrite", MW_RegWrite, 0);
        chk("rst_mw_memdata", MW_MemData, 0);
        chk("rst_stall", mem_stall, 0);
        rst = 1'b0;
        tick();

        // ALU instruction and branch pass-through
        XM_RegWrite = 1'b1; ALUout = 32'h55; XM_RD = 5'd3;
        XM_branch = 1'b1; XM_BT = 32'h400;
        #1;
        chk("pc_src", pc_src, 1);
        chk("pc_target", pc_target, 32'h400);
        chk("alu_stall", mem_stall, 0);
        tick();
        chk("alu_mw_aluout", MW_ALUout, 32'h55);
        chk("alu_mw_rd", MW_RD, 3);
        chk("alu_mw_regwrite", MW_RegWrite, 1);
        set_nop();

        // 1: lw 0x10, ack on first REQ cycle
        set_lw(32'h10, 5'd5);
        #1;
        chk("t1_stall_idle", mem_stall, 1);
        tick();
        chk("t1_req", mem_req, 1);
        chk("t1_we", mem_we, 0);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_stall_req", mem_stall, 1);
        chk("t1_bubble", MW_RegWrite, 0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("t1_req_drop", mem_req, 0);
        chk("t1_stall_done", mem_stall, 0);
        chk("t1_memdata", MW_MemData, 32'hDEADBEEF);
        tick();
        set_nop();
        chk("t1_mw_regwrite", MW_RegWrite, 1);
        chk("t1_mw_memtoreg", MW_MemtoReg, 1);
        chk("t1_mw_rd", MW_RD, 5);

        // Stray ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'h1111;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_memdata", MW_MemData, 32'hDEADBEEF);
        chk("stray_ack_req", mem_req, 0);

        // 2: sw 0x20 data 0x1234, ack in the 4th REQ cycle
        XM_MemWrite = 1'b1; ALUout = 32'h20; XM_SD = 32'h1234;
        #1;
        chk("t2_stall_idle", mem_stall, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_req", mem_req, 1);
            chk("t2_we", mem_we, 1);
            chk("t2_addr", mem_addr, 32'h20);
            chk("t2_wdata", mem_wdata, 32'h1234);
            chk("t2_stall", mem_stall, 1);
            if (i == 1) ALUout = 32'h99;
            if (i == 2) ALUout = 32'h20;
            if (i == 3) mem_ack = 1'b1;
        end
        tick();
        mem_ack = 1'b0;
        chk("t2_req_drop", mem_req, 0);
        chk("t2_stall_done", mem_stall, 0);
        tick();
        set_nop();
        chk("t2_mw_regwrite", MW_RegWrite, 0);
        chk("t2_memdata_kept", MW_MemData, 32'hDEADBEEF);

        // 3: misaligned lw 0x13
        set_lw(32'h13, 5'd7);
        #1;
        chk("t3_no_stall", mem_stall, 0);
        tick();
        set_nop();
        chk("t3_misalign", misalign_err, 1);
        chk("t3_no_req", mem_req, 0);
        chk("t3_bubble_rw", MW_RegWrite, 0);
        chk("t3_bubble_m2r", MW_MemtoReg, 0);
        chk("t3_memdata_kept", MW_MemData, 32'hDEADBEEF);
        tick();
        chk("t3_misalign_pulse", misalign_err, 0);

        // 4: lw 0x40 with no ack -> timeout
        set_lw(32'h40, 5'd9);
        req_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (mem_req) req_cycles++;
        end
        chk("t4_req_cycles", req_cycles, 16);
        chk("t4_no_buserr_yet", bus_err, 0);
        tick();
        chk("t4_req_drop", mem_req, 0);
        chk("t4_bus_err", bus_err, 1);
        chk("t4_stall_done", mem_stall, 0);
        tick();
        set_nop();
        chk("t4_bus_err_pulse", bus_err, 0);
        chk("t4_mw_regwrite", MW_RegWrite, 0);
        chk("t4_memdata_kept", MW_MemData, 32'hDEADBEEF);

        // 5: ack arrives on the last REQ cycle
        set_lw(32'h44, 5'd10);
        for (int i = 0; i < 16; i++) tick();
        chk("t5_req_last", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("t5_no_bus_err", bus_err, 0);
        chk("t5_memdata", MW_MemData, 32'hCAFEF00D);
        tick();
        set_nop();
        chk("t5_mw_regwrite", MW_RegWrite, 1);
        chk("t5_mw_rd", MW_RD, 10);

        // 6: reset in the middle of REQ
        set_lw(32'h48, 5'd11);
        tick(); tick();
        chk("t6_req_before", mem_req, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_req_rst", mem_req, 0);
        chk("t6_stall_rst", mem_stall, 0);
        chk("t6_memdata_rst", MW_MemData, 0);
        chk("t6_mw_rd_rst", MW_RD, 0);
        set_nop();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_idle_req", mem_req, 0);
        chk("t6_idle_stall", mem_stall, 0);
        set_lw(32'h4C, 5'd12);
        #1;
        chk("t6_restart_stall", mem_stall, 1);
        tick();
        chk("t6_restart_req", mem_req, 1);
        chk("t6_restart_addr", mem_addr, 32'h4C);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 1'b0;
        chk("t6_restart_done", mem_req, 0);
        chk("t6_restart_data", MW_MemData, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
